udt_pkt_arbiter: RTL and testbench

- Packet-level arbiter that shares a single 64-bit AXI-Stream path among NUM_SRC packet sources (DATA, ACK, NAK, keep-alive, …) and feeds the downstream packet processing/transmit path.
- Grants whole packets: a grant is held from first beat to the tlast beat, so packets are never interleaved.
- Sources flagged in HI_PRI_MASK (control packets) always win over the others; sources within the same class share round-robin.

---
 rtl/udt_pkt_arbiter.sv | 150 +++++++++++++++
 tb/tb_udt_pkt_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udt_pkt_arbiter.sv
// Whole-packet arbiter: strict priority for HI_PRI_MASK sources, round-robin within each class.
// Latency 1 cycle request-to-first-beat; m_tready low stalls only the owner's s_tready.
module udt_pkt_arbiter #(
  parameter int                 NUM_SRC     = 4,
  parameter logic [NUM_SRC-1:0] HI_PRI_MASK = 4'b1110,
  parameter int                 MAX_BEATS   = 256
) (
  input  logic                    core_clk,
  input  logic                    core_rst,
  input  logic [64*NUM_SRC-1:0]   s_tdata,
  input  logic [8*NUM_SRC-1:0]    s_tkeep,
  input  logic [NUM_SRC-1:0]      s_tvalid,
  input  logic [NUM_SRC-1:0]      s_tlast,
  output logic [NUM_SRC-1:0]      s_tready,
  output logic [63:0]             m_tdata,
  output logic [7:0]              m_tkeep,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    wdog_err
);

  localparam int              CNT_W     = $clog2(MAX_BEATS + 1);
  localparam logic [7:0]      HI_PAD    = 8'(HI_PRI_MASK);
  localparam logic [2:0]      LAST_SRC  = 3'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [2:0]       grant_q, grant_nxt;
  logic [2:0]       hi_ptr, hi_ptr_nxt, lo_ptr, lo_ptr_nxt, nxt_ptr;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             wdog_q, wdog_nxt, wdog_hit, xfer;

  // Sources padded to the full 3-bit grant space so grant_q indexes cleanly.
  logic [63:0] src_dat  [8];
  logic [7:0]  src_keep [8];
  logic [7:0]  vld_pad, last_pad;

  assign vld_pad  = 8'(s_tvalid);
  assign last_pad = 8'(s_tlast);

  for (genvar i = 0; i < 8; i++) begin : g_pad
    if (i < NUM_SRC) begin : g_src
      assign src_dat[i]  = s_tdata[64*i +: 64];
      assign src_keep[i] = s_tkeep[8*i +: 8];
    end else begin : g_none
      assign src_dat[i]  = '0;
      assign src_keep[i] = '0;
    end
  end

  logic [7:0] hi_req, lo_req, req;
  logic [2:0] ptr, win, idx;
  logic       use_hi, found;

  always_comb begin
    hi_req = vld_pad & HI_PAD;
    lo_req = vld_pad & ~HI_PAD;
    use_hi = |hi_req;
    req    = use_hi ? hi_req : lo_req;
    ptr    = use_hi ? hi_ptr : lo_ptr;
    win    = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = 3'((int'(ptr) + k) % NUM_SRC);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Reset gates the handshake so an abandoned packet never moves a beat.
  always_comb begin
    m_tdata  = src_dat[grant_q];
    m_tkeep  = src_keep[grant_q];
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    wdog_hit = 1'b0;
    if (state == BUSY && !core_rst) begin
      m_tvalid = vld_pad[grant_q];
      wdog_hit = (beat_cnt == LAST_BEAT) && !last_pad[grant_q];
      m_tlast  = last_pad[grant_q] | wdog_hit;
      s_tready = NUM_SRC'(m_tready) << grant_q;
    end
  end

  assign xfer    = m_tvalid & m_tready;
  assign nxt_ptr = (grant_q == LAST_SRC) ? 3'd0 : grant_q + 3'd1;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_q;
    hi_ptr_nxt   = hi_ptr;
    lo_ptr_nxt   = lo_ptr;
    beat_cnt_nxt = beat_cnt;
    wdog_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (|vld_pad) begin
          grant_nxt = win;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          if (m_tlast) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
            wdog_nxt     = wdog_hit;
            if (HI_PAD[grant_q]) hi_ptr_nxt = nxt_ptr;
            else                 lo_ptr_nxt = nxt_ptr;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      hi_ptr   <= '0;
      lo_ptr   <= '0;
      beat_cnt <= '0;
      wdog_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      hi_ptr   <= hi_ptr_nxt;
      lo_ptr   <= lo_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      wdog_q   <= wdog_nxt;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state == BUSY);
  assign wdog_err = wdog_q;

endmodule

// File: tb/tb_udt_pkt_arbiter.sv
// Directed bench for udt_pkt_arbiter (NUM_SRC=4, sources 1..3 high priority, MAX_BEATS=4).
module tb_udt_pkt_arbiter;

  typedef struct packed {
    logic [2:0]  gid;
    logic        last;
    logic [63:0] dat;
  } beat_t;

  logic         core_clk;
  logic         core_rst;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tlast;
  logic [3:0]   s_tready;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready;
  logic [2:0]   grant_id;
  logic         busy;
  logic         wdog_err;

  udt_pkt_arbiter #(.NUM_SRC(4), .HI_PRI_MASK(4'b1110), .MAX_BEATS(4)) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .grant_id(grant_id), .busy(busy), .wdog_err(wdog_err)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wdog_cnt = 0;

  logic [64:0] srcq [4][$];
  beat_t       olog [$];

  logic        snap_busy, snap_mvld, snap_mlast, snap_wdog;
  logic [2:0]  snap_gid;
  logic [63:0] snap_mdat;
  logic [7:0]  snap_mkeep;
  logic [3:0]  snap_srdy;

  task automatic push(input int s, input logic [63:0] d, input logic last);
    srcq[s].push_back({last, d});
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < 4; i++) begin
      if (srcq[i].size() > 0) begin
        s_tvalid[i]         = 1'b1;
        s_tlast[i]          = srcq[i][0][64];
        s_tdata[64*i +: 64] = srcq[i][0][63:0];
        s_tkeep[8*i +: 8]   = 8'hFF;
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tlast[i]          = 1'b0;
        s_tdata[64*i +: 64] = '0;
        s_tkeep[8*i +: 8]   = '0;
      end
    end
  endtask

  // One clock: snapshot outputs mid-cycle, then advance sources that handshook.
  task automatic step();
    logic [3:0] hs;
    #3;
    hs         = s_tvalid & s_tready;
    snap_busy  = busy;
    snap_gid   = grant_id;
    snap_mvld  = m_tvalid;
    snap_mdat  = m_tdata;
    snap_mlast = m_tlast;
    snap_mkeep = m_tkeep;
    snap_srdy  = s_tready;
    snap_wdog  = wdog_err;
    if (m_tvalid && m_tready) olog.push_back({grant_id, m_tlast, m_tdata});
    if (wdog_err) wdog_cnt++;
    @(posedge core_clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) void'(srcq[i].pop_front());
    drive_srcs();
  endtask

  task automatic do_reset();
    core_rst = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) srcq[i].delete();
    drive_srcs();
    step();
    step();
    core_rst = 1'b0;
    olog.delete();
    wdog_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    n_cmp++; if (snap_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", snap_busy); end
    n_cmp++; if (snap_gid !== 3'd0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", snap_gid); end
    n_cmp++; if (snap_wdog !== 1'b0) begin n_bad++; $display("FAIL reset_wdog: got %b want 0", snap_wdog); end
    n_cmp++; if (snap_mvld !== 1'b0) begin n_bad++; $display("FAIL reset_mvld: got %b want 0", snap_mvld); end
    n_cmp++; if (snap_srdy !== 4'b0) begin n_bad++; $display("FAIL reset_srdy: got %b want 0000", snap_srdy); end
  endtask

  task automatic test_single();
    beat_t exp_b [3];
    exp_b[0] = {3'd0, 1'b0, 64'h11};
    exp_b[1] = {3'd0, 1'b0, 64'h22};
    exp_b[2] = {3'd0, 1'b1, 64'h33};
    do_reset();
    push(0, 64'h11, 1'b0); push(0, 64'h22, 1'b0); push(0, 64'h33, 1'b1);
    drive_srcs();
    step();
    n_cmp++; if (snap_mvld !== 1'b0) begin n_bad++; $display("FAIL single_req_cycle_mvld: got %b want 0", snap_mvld); end
    step();
    n_cmp++; if (snap_mvld !== 1'b1) begin n_bad++; $display("FAIL single_first_mvld: got %b want 1", snap_mvld); end
    n_cmp++; if (snap_mdat !== 64'h11) begin n_bad++; $display("FAIL single_first_dat: got %h want 11", snap_mdat); end
    n_cmp++; if (snap_mkeep !== 8'hFF) begin n_bad++; $display("FAIL single_keep: got %h want ff", snap_mkeep); end
    n_cmp++; if (snap_srdy !== 4'b0001) begin n_bad++; $display("FAIL single_srdy: got %b want 0001", snap_srdy); end
    n_cmp++; if (snap_gid !== 3'd0 || snap_busy !== 1'b1) begin n_bad++; $display("FAIL single_grant: got gid=%0d busy=%b want 0/1", snap_gid, snap_busy); end
    step();
    step();
    n_cmp++; if (snap_mlast !== 1'b1) begin n_bad++; $display("FAIL single_tlast: got %b want 1", snap_mlast); end
    step();
    n_cmp++; if (snap_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_drop: got %b want 0", snap_busy); end
    n_cmp++; if (olog.size() != 3) begin n_bad++; $display("FAIL single_count: got %0d want 3", olog.size()); end
    for (int k = 0; k < 3; k++) if (k < olog.size()) begin
      n_cmp++; if (olog[k] !== exp_b[k]) begin n_bad++; $display("FAIL single_beat%0d: got %h want %h", k, olog[k], exp_b[k]); end
    end
  endtask

  task automatic test_priority();
    beat_t exp_b [3];
    exp_b[0] = {3'd2, 1'b0, 64'hC0};
    exp_b[1] = {3'd2, 1'b1, 64'hC1};
    exp_b[2] = {3'd0, 1'b1, 64'hA0};
    do_reset();
    push(0, 64'hA0, 1'b1);
    push(2, 64'hC0, 1'b0); push(2, 64'hC1, 1'b1);
    drive_srcs();
    step();
    step();
    n_cmp++; if (snap_gid !== 3'd2) begin n_bad++; $display("FAIL prio_winner: got %0d want 2", snap_gid); end
    step();
    step();
    n_cmp++; if (snap_busy !== 1'b0) begin n_bad++; $display("FAIL prio_gap: got busy=%b want 0", snap_busy); end
    step();
    n_cmp++; if (snap_gid !== 3'd0 || snap_busy !== 1'b1) begin n_bad++; $display("FAIL prio_second: got gid=%0d busy=%b want 0/1", snap_gid, snap_busy); end
    step();
    n_cmp++; if (olog.size() != 3) begin n_bad++; $display("FAIL prio_count: got %0d want 3", olog.size()); end
    for (int k = 0; k < 3; k++) if (k < olog.size()) begin
      n_cmp++; if (olog[k] !== exp_b[k]) begin n_bad++; $display("FAIL prio_beat%0d: got %h want %h", k, olog[k], exp_b[k]); end
    end
  endtask

  task automatic test_no_preempt();
    beat_t exp_b [5];
    exp_b[0] = {3'd0, 1'b0, 64'hD0};
    exp_b[1] = {3'd0, 1'b0, 64'hD1};
    exp_b[2] = {3'd0, 1'b0, 64'hD2};
    exp_b[3] = {3'd0, 1'b1, 64'hD3};
    exp_b[4] = {3'd1, 1'b1, 64'hE0};
    do_reset();
    push(0, 64'hD0, 1'b0); push(0, 64'hD1, 1'b0); push(0, 64'hD2, 1'b0); push(0, 64'hD3, 1'b1);
    drive_srcs();
    step();
    step();
    push(1, 64'hE0, 1'b1);
    drive_srcs();
    step();
    n_cmp++; if (snap_gid !== 3'd0 || snap_srdy !== 4'b0001) begin n_bad++; $display("FAIL nopre_hold: got gid=%0d srdy=%b want 0/0001", snap_gid, snap_srdy); end
    for (int c = 0; c < 5; c++) step();
    n_cmp++; if (olog.size() != 5) begin n_bad++; $display("FAIL nopre_count: got %0d want 5", olog.size()); end
    for (int k = 0; k < 5; k++) if (k < olog.size()) begin
      n_cmp++; if (olog[k] !== exp_b[k]) begin n_bad++; $display("FAIL nopre_beat%0d: got %h want %h", k, olog[k], exp_b[k]); end
    end
    n_cmp++; if (wdog_cnt != 0) begin n_bad++; $display("FAIL nopre_wdog: got %0d pulses want 0", wdog_cnt); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [7];
    exp_g = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd0};
    do_reset();
    push(1, 64'h1A, 1'b1); push(1, 64'h1B, 1'b1);
    push(2, 64'h2A, 1'b1); push(2, 64'h2B, 1'b1);
    push(3, 64'h3A, 1'b1); push(3, 64'h3B, 1'b1);
    push(0, 64'h0A, 1'b1);
    drive_srcs();
    for (int c = 0; c < 16; c++) step();
    n_cmp++; if (olog.size() != 7) begin n_bad++; $display("FAIL rr_count: got %0d want 7", olog.size()); end
    for (int k = 0; k < 7; k++) if (k < olog.size()) begin
      n_cmp++; if (olog[k].gid !== exp_g[k]) begin n_bad++; $display("FAIL rr_order%0d: got %0d want %0d", k, olog[k].gid, exp_g[k]); end
    end
  endtask

  task automatic test_backpressure();
    beat_t exp_b [4];
    exp_b[0] = {3'd0, 1'b0, 64'hF0};
    exp_b[1] = {3'd0, 1'b0, 64'hF1};
    exp_b[2] = {3'd0, 1'b0, 64'hF2};
    exp_b[3] = {3'd0, 1'b1, 64'hF3};
    do_reset();
    push(0, 64'hF0, 1'b0); push(0, 64'hF1, 1'b0); push(0, 64'hF2, 1'b0); push(0, 64'hF3, 1'b1);
    drive_srcs();
    step();
    step();
    m_tready = 1'b0;
    step();
    n_cmp++; if (snap_mvld !== 1'b1 || snap_mdat !== 64'hF1) begin n_bad++; $display("FAIL bp_stall1: got vld=%b dat=%h want 1/f1", snap_mvld, snap_mdat); end
    n_cmp++; if (snap_srdy !== 4'b0000) begin n_bad++; $display("FAIL bp_srdy_low: got %b want 0000", snap_srdy); end
    step();
    n_cmp++; if (snap_mdat !== 64'hF1 || snap_srdy !== 4'b0000) begin n_bad++; $display("FAIL bp_stall2: got dat=%h srdy=%b want f1/0000", snap_mdat, snap_srdy); end
    m_tready = 1'b1;
    step();
    n_cmp++; if (snap_srdy !== 4'b0001 || snap_mdat !== 64'hF1) begin n_bad++; $display("FAIL bp_resume: got srdy=%b dat=%h want 0001/f1", snap_srdy, snap_mdat); end
    for (int c = 0; c < 3; c++) step();
    n_cmp++; if (olog.size() != 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", olog.size()); end
    for (int k = 0; k < 4; k++) if (k < olog.size()) begin
      n_cmp++; if (olog[k] !== exp_b[k]) begin n_bad++; $display("FAIL bp_beat%0d: got %h want %h", k, olog[k], exp_b[k]); end
    end
  endtask

  task automatic test_watchdog();
    beat_t exp_b [6];
    exp_b[0] = {3'd3, 1'b0, 64'h30};
    exp_b[1] = {3'd3, 1'b0, 64'h31};
    exp_b[2] = {3'd3, 1'b0, 64'h32};
    exp_b[3] = {3'd3, 1'b1, 64'h33};
    exp_b[4] = {3'd3, 1'b0, 64'h34};
    exp_b[5] = {3'd3, 1'b1, 64'h35};
    do_reset();
    for (int b = 0; b < 6; b++) push(3, 64'h30 + 64'(b), (b == 5));
    drive_srcs();
    for (int c = 0; c < 5; c++) step();
    n_cmp++; if (snap_mlast !== 1'b1 || snap_mdat !== 64'h33) begin n_bad++; $display("FAIL wd_forced_last: got last=%b dat=%h want 1/33", snap_mlast, snap_mdat); end
    step();
    n_cmp++; if (snap_wdog !== 1'b1 || snap_busy !== 1'b0) begin n_bad++; $display("FAIL wd_pulse: got wdog=%b busy=%b want 1/0", snap_wdog, snap_busy); end
    step();
    n_cmp++; if (snap_wdog !== 1'b0 || snap_gid !== 3'd3 || snap_busy !== 1'b1) begin n_bad++; $display("FAIL wd_regrant: got wdog=%b gid=%0d busy=%b want 0/3/1", snap_wdog, snap_gid, snap_busy); end
    step();
    step();
    n_cmp++; if (wdog_cnt != 1) begin n_bad++; $display("FAIL wd_pulse_count: got %0d want 1", wdog_cnt); end
    n_cmp++; if (olog.size() != 6) begin n_bad++; $display("FAIL wd_count: got %0d want 6", olog.size()); end
    for (int k = 0; k < 6; k++) if (k < olog.size()) begin
      n_cmp++; if (olog[k] !== exp_b[k]) begin n_bad++; $display("FAIL wd_beat%0d: got %h want %h", k, olog[k], exp_b[k]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(0, 64'h40, 1'b0); push(0, 64'h41, 1'b0); push(0, 64'h42, 1'b0); push(0, 64'h43, 1'b1);
    drive_srcs();
    step();
    step();
    core_rst = 1'b1;
    step();
    n_cmp++; if (snap_srdy !== 4'b0000) begin n_bad++; $display("FAIL rstmid_no_hs: got srdy=%b want 0000", snap_srdy); end
    core_rst = 1'b0;
    step();
    n_cmp++; if (snap_busy !== 1'b0 || snap_mvld !== 1'b0 || snap_srdy !== 4'b0000) begin n_bad++; $display("FAIL rstmid_after: got busy=%b vld=%b srdy=%b want 0/0/0000", snap_busy, snap_mvld, snap_srdy); end
    n_cmp++; if (olog.size() != 1) begin n_bad++; $display("FAIL rstmid_beats: got %0d want 1", olog.size()); end
  endtask

  initial begin
    core_rst = 1'b1;
    m_tready = 1'b1;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    @(posedge core_clk);
    #1;
    test_reset();
    test_single();
    test_priority();
    test_no_preempt();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
